// File: rtl/stage4_memory.sv
// -----------------------------------------------------------------------------
// stage4_memory
//
// Memory-access pipeline stage between execute and write-back. The execute
// stage's ALU result is the effective address and its forwarded rs2 value is
// the store data. Each access runs one request/grant/response transaction on
// the data-memory port. The upstream pipeline is stalled for the whole access.
// Load data is returned sign- or zero-extended.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   alu_result_i       effective address
//   write_data_i       store data (forwarded rs2)
//   mem_read_i         load in the MEM slot
//   mem_write_i        store in the MEM slot
//   rw_size_i          00 byte, 01 half, 10 word, 11 illegal
//   ld_unsigned_i      zero-extend the load result
//   dmem_req_o         request valid
//   dmem_gnt_i         request accepted this cycle
//   dmem_we_o          write enable
//   dmem_addr_o        word-aligned address
//   dmem_wdata_o       lane-replicated store data
//   dmem_wstrb_o       byte strobes
//   dmem_rvalid_i      response valid (load data or store ack)
//   dmem_rdata_i       response data
//   rdata_o            formatted load data, valid in the DONE cycle
//   mem_stall_o        freeze the upstream pipeline
//   misalign_o         misaligned or illegal-size access
//   bus_err_o          response timeout, pulses in the DONE cycle
// -----------------------------------------------------------------------------
module stage4_memory #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] write_data_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [1:0]      rw_size_i,
    input  logic            ld_unsigned_i,
    output logic            dmem_req_o,
    input  logic            dmem_gnt_i,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [3:0]      dmem_wstrb_o,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            mem_stall_o,
    output logic            misalign_o,
    output logic            bus_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] tmo_cnt;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [3:0]       wstrb_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             unsigned_q;
    logic [XLEN-1:0]  rdata_q;
    logic             bus_err_q;

    logic             acc;
    logic             misaligned;
    logic             go;
    logic             timed_out;
    logic [XLEN-1:0]  fmt_wdata;
    logic [3:0]       fmt_wstrb;

    logic             req;
    logic             stall;
    logic             misalign;

    // Extract the addressed byte/half from the response word and extend it.
    function automatic logic [XLEN-1:0] format_load(
        input logic [XLEN-1:0] raw,
        input logic [1:0]      off,
        input logic [1:0]      size,
        input logic            uns
    );
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] result;
        shifted = raw;
        result  = raw;
        case (size)
            2'b00: begin
                shifted = raw >> {off, 3'b000};
                result  = uns ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                              : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                shifted = raw >> {off[1], 4'b0000};
                result  = uns ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                              : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            end
            default: result = raw;
        endcase
        return result;
    endfunction

    // Decode the incoming instruction and build the store lanes/strobes.
    // Only stores drive strobes; loads always present 0000.
    always_comb begin
        acc        = mem_read_i | mem_write_i;
        misaligned = 1'b0;
        fmt_wdata  = write_data_i;
        fmt_wstrb  = 4'b1111;
        case (rw_size_i)
            2'b00: begin
                fmt_wdata = {4{write_data_i[7:0]}};
                fmt_wstrb = 4'b0001 << alu_result_i[1:0];
            end
            2'b01: begin
                misaligned = alu_result_i[0];
                fmt_wdata  = {2{write_data_i[15:0]}};
                fmt_wstrb  = 4'b0011 << {alu_result_i[1], 1'b0};
            end
            2'b10: begin
                misaligned = |alu_result_i[1:0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
        if (!mem_write_i) begin
            fmt_wstrb = 4'b0000;
        end
        go = acc & ~misaligned;
    end

    assign timed_out = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Next-state and bus-side outputs. In IDLE the request is presented
    // straight from the inputs so a grant can be taken in the same cycle;
    // afterwards the captured copies keep the fields stable.
    always_comb begin
        state_next   = state;
        req          = 1'b0;
        stall        = 1'b0;
        misalign     = 1'b0;
        dmem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
        dmem_wdata_o = wdata_q;
        dmem_wstrb_o = wstrb_q;
        dmem_we_o    = we_q;
        case (state)
            IDLE: begin
                dmem_addr_o  = {alu_result_i[XLEN-1:2], 2'b00};
                dmem_wdata_o = fmt_wdata;
                dmem_wstrb_o = fmt_wstrb;
                dmem_we_o    = mem_write_i;
                req          = go;
                stall        = go;
                misalign     = acc & misaligned;
                if (go) begin
                    state_next = dmem_gnt_i ? WAIT_RSP : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (dmem_gnt_i) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                stall = 1'b1;
                if (dmem_rvalid_i || timed_out) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The decoded inputs are combinational, so the control outputs are
    // also held low while reset is asserted.
    assign dmem_req_o  = req & rst_ni;
    assign mem_stall_o = stall & rst_ni;
    assign misalign_o  = misalign & rst_ni;
    assign rdata_o     = rdata_q;
    assign bus_err_o   = bus_err_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request when it launches so later cycles no longer depend
    // on the (possibly changing) upstream inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
        end else if (state == IDLE && go) begin
            addr_q     <= alu_result_i;
            wdata_q    <= fmt_wdata;
            wstrb_q    <= fmt_wstrb;
            we_q       <= mem_write_i;
            size_q     <= rw_size_i;
            unsigned_q <= ld_unsigned_i;
        end
    end

    // Response handling. A response in the timeout cycle still wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if (state == WAIT_RSP) begin
                if (dmem_rvalid_i) begin
                    tmo_cnt <= '0;
                    if (!we_q) begin
                        rdata_q <= format_load(dmem_rdata_i, addr_q[1:0], size_q, unsigned_q);
                    end
                end else if (timed_out) begin
                    tmo_cnt   <= '0;
                    rdata_q   <= '0;
                    bus_err_q <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stage4_memory.sv
// -----------------------------------------------------------------------------
// tb_stage4_memory
//
// Self-checking bench for stage4_memory with a short response timeout.
// Expected load results are queued when each access is launched and
// compared when the stage reaches its DONE cycle.
// -----------------------------------------------------------------------------
module tb_stage4_memory;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] write_data_i = '0;
    logic        mem_read_i = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [1:0]  rw_size_i = '0;
    logic        ld_unsigned_i = 1'b0;
    logic        dmem_req_o;
    logic        dmem_gnt_i = 1'b0;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic [31:0] rdata_o;
    logic        mem_stall_o;
    logic        misalign_o;
    logic        bus_err_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbQueue[$];
    int   assertCount = 0;
    int   failCount = 0;

    stage4_memory #(
        .XLEN(32),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .alu_result_i(alu_result_i),
        .write_data_i(write_data_i),
        .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i),
        .rw_size_i(rw_size_i),
        .ld_unsigned_i(ld_unsigned_i),
        .dmem_req_o(dmem_req_o),
        .dmem_gnt_i(dmem_gnt_i),
        .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o),
        .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i),
        .rdata_o(rdata_o),
        .mem_stall_o(mem_stall_o),
        .misalign_o(misalign_o),
        .bus_err_o(bus_err_o)
    );

    // 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        alu_result_i  = '0;
        write_data_i  = '0;
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        rw_size_i     = '0;
        ld_unsigned_i = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    // Runs one complete access. Called in an IDLE cycle at posedge+1 and
    // returns in the IDLE cycle that follows DONE, at posedge+1.
    // rspDelay is the WAIT_RSP cycle index that gets rvalid (-1 = never).
    task automatic applyStimulus(
        input logic [31:0] addr,
        input logic [31:0] wd,
        input logic        rd,
        input logic        wr,
        input logic [1:0]  size,
        input logic        uns,
        input int          gntDelay,
        input int          rspDelay,
        input logic [31:0] rspData,
        input logic [31:0] expAddr,
        input logic [31:0] expWdata,
        input logic [3:0]  expWstrb,
        input logic [31:0] expRdata,
        input logic        expErr,
        input int          expRspCycles,
        input int          expStall
    );
        exp_t e;
        int   stallCount;
        int   rspCycles;
        e.rdata = expRdata;
        e.err   = expErr;
        sbQueue.push_back(e);
        stallCount = 0;

        alu_result_i  = addr;
        write_data_i  = wd;
        mem_read_i    = rd;
        mem_write_i   = wr;
        rw_size_i     = size;
        ld_unsigned_i = uns;
        dmem_gnt_i    = (gntDelay == 0);
        dmem_rvalid_i = 1'b0;
        #1;
        checkOutput("req_idle", {31'b0, dmem_req_o}, 32'd1);
        checkOutput("addr_idle", dmem_addr_o, expAddr);
        checkOutput("wstrb_idle", {28'b0, dmem_wstrb_o}, {28'b0, expWstrb});
        checkOutput("we_idle", {31'b0, dmem_we_o}, {31'b0, wr});
        if (wr) checkOutput("wdata_idle", dmem_wdata_o, expWdata);
        checkOutput("misalign_idle", {31'b0, misalign_o}, 32'd0);
        if (mem_stall_o) stallCount++;

        for (int k = 0; k < gntDelay; k++) begin
            @(posedge clk_i); #1;
            alu_result_i = ~addr;
            write_data_i = ~wd;
            #1;
            checkOutput("req_hold", {31'b0, dmem_req_o}, 32'd1);
            checkOutput("addr_hold", dmem_addr_o, expAddr);
            checkOutput("wstrb_hold", {28'b0, dmem_wstrb_o}, {28'b0, expWstrb});
            checkOutput("we_hold", {31'b0, dmem_we_o}, {31'b0, wr});
            if (wr) checkOutput("wdata_hold", dmem_wdata_o, expWdata);
            if (mem_stall_o) stallCount++;
            dmem_gnt_i = (k == gntDelay - 1);
        end

        @(posedge clk_i); #1;
        dmem_gnt_i   = 1'b0;
        alu_result_i = ~addr;
        write_data_i = ~wd;
        #1;
        rspCycles = 0;
        while (mem_stall_o === 1'b1 && rspCycles < 50) begin
            stallCount++;
            checkOutput("req_rsp", {31'b0, dmem_req_o}, 32'd0);
            dmem_rvalid_i = (rspCycles == rspDelay);
            dmem_rdata_i  = rspData;
            @(posedge clk_i); #1;
            rspCycles++;
        end
        dmem_rvalid_i = 1'b0;
        checkOutput("rsp_cycles", rspCycles, expRspCycles);
        checkOutput("stall_cycles", stallCount, expStall);

        if (sbQueue.size() == 0) begin
            checkOutput("sb_empty_at_done", 32'd0, 32'd1);
        end else begin
            e = sbQueue.pop_front();
            checkOutput("rdata_done", rdata_o, e.rdata);
            checkOutput("bus_err_done", {31'b0, bus_err_o}, {31'b0, e.err});
        end
        checkOutput("req_done", {31'b0, dmem_req_o}, 32'd0);

        clearInputs();
        @(posedge clk_i); #1;
        checkOutput("bus_err_after", {31'b0, bus_err_o}, 32'd0);
        checkOutput("rdata_hold", rdata_o, expRdata);
    endtask

    logic [31:0] misAddr[3]  = '{32'h0000_3001, 32'h0000_3003, 32'h0000_3000};
    logic [1:0]  misSize[3]  = '{2'b10, 2'b01, 2'b11};

    initial begin
        #12;
        checkOutput("rst_rdata", rdata_o, 32'd0);
        checkOutput("rst_req", {31'b0, dmem_req_o}, 32'd0);
        checkOutput("rst_stall", {31'b0, mem_stall_o}, 32'd0);
        checkOutput("rst_misalign", {31'b0, misalign_o}, 32'd0);
        checkOutput("rst_bus_err", {31'b0, bus_err_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // LB / LBU at byte 3 of the word at 0x1000.
        applyStimulus(32'h1003, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 0, 0, 32'h8012_3456,
                      32'h1000, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b0, 1, 2);
        applyStimulus(32'h1003, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 0, 0, 32'h8012_3456,
                      32'h1000, 32'h0, 4'b0000, 32'h0000_0080, 1'b0, 1, 2);

        // SH to the upper half with the grant held off for 3 cycles.
        applyStimulus(32'h2002, 32'hAAAA_BEEF, 1'b0, 1'b1, 2'b01, 1'b0, 3, 0, 32'hDEAD_BEEF,
                      32'h2000, 32'hBEEF_BEEF, 4'b1100, 32'h0000_0080, 1'b0, 1, 5);

        // Misaligned and illegal-size accesses never leave IDLE.
        for (int i = 0; i < 3; i++) begin
            alu_result_i = misAddr[i];
            mem_read_i   = 1'b1;
            rw_size_i    = misSize[i];
            dmem_gnt_i   = 1'b1;
            #1;
            checkOutput("misalign_flag", {31'b0, misalign_o}, 32'd1);
            checkOutput("misalign_req", {31'b0, dmem_req_o}, 32'd0);
            checkOutput("misalign_stall", {31'b0, mem_stall_o}, 32'd0);
            @(posedge clk_i); #1;
            checkOutput("misalign_stays_idle", {31'b0, misalign_o}, 32'd1);
            checkOutput("misalign_req2", {31'b0, dmem_req_o}, 32'd0);
            clearInputs();
            #1;
            checkOutput("misalign_clear", {31'b0, misalign_o}, 32'd0);
            @(posedge clk_i); #1;
        end

        // LW whose response never arrives: four WAIT_RSP cycles then error.
        applyStimulus(32'h5000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 0, -1, 32'h1111_2222,
                      32'h5000, 32'h0, 4'b0000, 32'h0000_0000, 1'b1, 4, 5);

        // Back-to-back LH; the second request must appear right after DONE.
        applyStimulus(32'h4002, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 0, 0, 32'h8001_7FFF,
                      32'h4000, 32'h0, 4'b0000, 32'hFFFF_8001, 1'b0, 1, 2);
        applyStimulus(32'h4000, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 0, 0, 32'h8001_7FFF,
                      32'h4000, 32'h0, 4'b0000, 32'h0000_7FFF, 1'b0, 1, 2);

        // Asynchronous reset in WAIT_RSP, late response afterwards.
        alu_result_i = 32'h6000;
        mem_read_i   = 1'b1;
        rw_size_i    = 2'b10;
        dmem_gnt_i   = 1'b1;
        @(posedge clk_i); #1;
        dmem_gnt_i = 1'b0;
        #1;
        checkOutput("pre_reset_stall", {31'b0, mem_stall_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("areset_req", {31'b0, dmem_req_o}, 32'd0);
        checkOutput("areset_stall", {31'b0, mem_stall_o}, 32'd0);
        checkOutput("areset_rdata", rdata_o, 32'd0);
        checkOutput("areset_bus_err", {31'b0, bus_err_o}, 32'd0);
        checkOutput("areset_misalign", {31'b0, misalign_o}, 32'd0);
        clearInputs();
        @(posedge clk_i); #1;
        rst_ni        = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1234_5678;
        @(posedge clk_i); #1;
        checkOutput("late_rsp_rdata", rdata_o, 32'd0);
        checkOutput("late_rsp_stall", {31'b0, mem_stall_o}, 32'd0);
        checkOutput("late_rsp_req", {31'b0, dmem_req_o}, 32'd0);
        dmem_rvalid_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("late_rsp_rdata2", rdata_o, 32'd0);

        // Normal operation resumes after reset.
        applyStimulus(32'h7004, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1, 2, 32'hCAFE_F00D,
                      32'h7004, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0, 3, 5);

        checkOutput("sb_drained", sbQueue.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
